picomips_input_sequencer: RTL and testbench
===========================================

Name: picomips_input_sequencer

Overview:
Host-side producer for the picoMIPS operand input handshake. It drives the CPU's `readyin`/`x` pair exactly as the CPU expects. Bytes queued on a simple valid/ready write port are presented one at a time on `x`. Each byte gets a `readyin` pulse held for a fixed number of cycles, then a mandatory low gap. It replaces manual switch stimulus on the board and in system benches, and sits directly in front of the `cpu` instance.

Parameters:
- WIDTH, 8, data byte width; must match the CPU `x` width
- DEPTH, 4, write FIFO entries; power of two, ≥2
- HOLD_CYCLES, 4, clocks `readyin` stays high per byte; ≥1
- GAP_CYCLES, 4, minimum clocks `readyin` stays low between bytes; ≥1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_data  in  WIDTH  byte to queue
- wr_ready  out  1  FIFO not full; a write is accepted when wr_valid && wr_ready
- flush  in  1  synchronous abort: drop queue, end current pulse
- readyin  out  1  to CPU: operand valid
- x  out  WIDTH  to CPU: operand byte
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, any state):
  - readyin=0, x=0, FIFO empty, level=0, wr_ready=1, busy=0, FSM=IDLE, counter=0.
- FSM states IDLE, HOLD, GAP; all outputs are registered.
- IDLE:
  - FIFO non-empty → pop head, x←head, readyin←1, cnt←HOLD_CYCLES-1, go to HOLD.
  - Latency: write accepted at edge k → readyin high from edge k+1, when the FIFO was empty and FSM in IDLE.
- HOLD:
  - cnt≠0 → decrement.
  - cnt=0 → readyin←0, cnt←GAP_CYCLES-1, go to GAP.
  - Result: readyin is high for exactly HOLD_CYCLES clocks.
  - x stays stable throughout HOLD and GAP; it changes only on the edge where readyin rises.
- GAP:
  - cnt≠0 → decrement.
  - cnt=0 and FIFO non-empty → load next byte directly (as IDLE does) and go to HOLD. Back-to-back bytes therefore see exactly GAP_CYCLES low clocks.
  - cnt=0 and FIFO empty → go to IDLE.
- FIFO:
  - wr_ready = !full, combinational from the registered count.
  - Write and pop in the same cycle are both honoured; level is unchanged.
  - Write while full is ignored with no corruption; wr_ready is already low.
  - Pointers wrap modulo DEPTH.
- flush (priority below reset, above all else):
  - Next edge: FIFO emptied, readyin←0, FSM←IDLE, cnt←0; x keeps its last value.
  - A write in the same cycle as flush is discarded.
- Reset mid-operation: readyin drops immediately (async), the queue is lost, and no partial pulse resumes after reset deasserts.
- No CPU acknowledge exists. Pulse timing alone defines the protocol; HOLD_CYCLES must cover the CPU's worst-case input poll loop.

Decomposition:
- picomips_pkg:
  - seq_state_t enum {IDLE, HOLD, GAP}
  - default WIDTH constant shared with the cpu
- Sub-module byte_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop/data/full/empty/level, flush.
  - Synchronous, registered count, async active-high reset.
- The top level holds only the FSM, the counter and the output registers.

Test Plan:
1. Assert reset, then release → readyin=0, x=0x00, wr_ready=1, busy=0, level=0.
2. Write 0x05 once → readyin high exactly 4 clocks with x=0x05, then 4 low clocks; busy=0 afterwards; x remains 0x05.
3. Write 0x05 then 0xFB on consecutive clocks → pulse 1 with x=0x05 (4 high), exactly 4 low, pulse 2 with x=0xFB (4 high). x switches only on the second rising edge.
4. Write 5 bytes 0x01..0x05 on consecutive clocks with the FSM idle:
   - The first byte pops on the clock after acceptance, so wr_ready never drops and all 5 are accepted (peak level=4).
   - Repeat the burst while the FSM is in HOLD, so no pop occurs: wr_ready drops after the 4th write and the 5th is dropped.
   - Output pulses carry the accepted bytes in order.
5. Queue 3 bytes, assert reset during the 2nd clock of the first HOLD → readyin falls before the next clock edge; after release there are no pulses, level=0, x=0x00.
6. Queue 3 bytes, pulse flush during the first GAP → readyin stays 0, level=0 next clock, busy=0, no further pulses; a subsequent write of 0x7E produces a normal single pulse.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS host-side input sequencer.
package picomips_pkg;

  localparam int unsigned CPU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered occupancy and a synchronous flush.
module byte_fifo
  import picomips_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign level_o   = count_q;
  assign rd_data_o = mem[rptr_q];

  // Writes while full are dropped here, so a full FIFO can never be corrupted.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/picomips_input_sequencer.sv
// Presents queued bytes to the picoMIPS CPU as fixed-length readyin pulses
// separated by a guaranteed low gap.
module picomips_input_sequencer
  import picomips_pkg::*;
#(
  parameter int unsigned WIDTH       = CPU_WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   readyin,
  output logic [WIDTH-1:0]       x,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             readyin_q, readyin_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             fifo_pop, fifo_full, fifo_empty, load;
  logic [WIDTH-1:0] fifo_head;

  byte_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (wr_valid),
    .wr_data_i (wr_data),
    .pop_i     (fifo_pop),
    .flush_i   (flush),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign wr_ready = !fifo_full;
  assign readyin  = readyin_q;
  assign x        = x_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;

  // IDLE and an expired GAP share one load path so back-to-back bytes see
  // exactly GAP_CYCLES low clocks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    readyin_d = readyin_q;
    x_d       = x_q;
    load      = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      readyin_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: load = !fifo_empty;
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            readyin_d = 1'b0;
            cnt_d     = CW'(GAP_CYCLES - 1);
            state_d   = GAP;
          end
        end
        GAP: begin
          if (cnt_q != '0)      cnt_d   = cnt_q - CW'(1);
          else if (!fifo_empty) load    = 1'b1;
          else                  state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (load) begin
        x_d       = fifo_head;
        readyin_d = 1'b1;
        cnt_d     = CW'(HOLD_CYCLES - 1);
        state_d   = HOLD;
      end
    end
    fifo_pop = load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      readyin_q <= 1'b0;
      x_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      readyin_q <= readyin_d;
      x_q       <= x_d;
    end
  end

endmodule

// File: tb/tb_picomips_input_sequencer.sv
// Directed and random checks of picomips_input_sequencer against a
// time-based reference model (pulse start times + a byte queue).
module tb_picomips_input_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int H  = 4;
  localparam int G  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          flush = 1'b0;
  logic          wr_ready, readyin, busy;
  logic [W-1:0]  x;
  logic [LW-1:0] level;

  int vectors = 0;
  int miscompares = 0;
  int hi_cnt = 0;

  // Reference model: a pulse rises at edge rise_e and lasts H edges; the next
  // rise is allowed no earlier than next_ok.
  logic [W-1:0] q[$];
  logic [W-1:0] x_m;
  int cyc, rise_e, next_ok;

  always #5 clk = ~clk;

  picomips_input_sequencer #(
    .WIDTH       (W),
    .DEPTH       (D),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .readyin  (readyin),
    .x        (x),
    .busy     (busy),
    .level    (level)
  );

  task automatic model_reset();
    q.delete();
    x_m     = '0;
    rise_e  = -1000;
    next_ok = 0;
  endtask

  task automatic model_edge();
    int  sz;
    bit  do_pop, do_push;
    cyc++;
    sz = q.size();
    if (flush) begin
      q.delete();
      rise_e  = -1000;
      next_ok = cyc;
    end else begin
      do_pop  = (sz != 0) && (cyc >= next_ok);
      do_push = wr_valid && (sz < D);
      if (do_pop) begin
        x_m     = q.pop_front();
        rise_e  = cyc;
        next_ok = cyc + H + G;
      end
      if (do_push) q.push_back(wr_data);
    end
  endtask

  function automatic logic [15:0] expected();
    logic          rdy, bsy, wrr;
    logic [LW-1:0] lvl;
    rdy = (cyc >= rise_e) && (cyc < rise_e + H);
    bsy = (cyc < next_ok) || (q.size() != 0);
    wrr = (q.size() < D);
    lvl = LW'(q.size());
    return 16'({rdy, x_m, lvl, wrr, bsy});
  endfunction

  function automatic logic [15:0] observed();
    return 16'({readyin, x, level, wr_ready, busy});
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    if (readyin === 1'b1) hi_cnt++;
    check(tag, observed(), expected());
  endtask

  task automatic put(input logic [W-1:0] d, input string tag);
    wr_valid = 1'b1;
    wr_data  = d;
    step(tag);
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    check("reset_state", observed(), 16'({1'b0, 8'h00, 3'd0, 1'b1, 1'b0}));
    idle(2, "post_reset");

    // 2: single byte
    hi_cnt = 0;
    put(8'h05, "t2_wr");
    idle(12, "t2_run");
    check("t2_hi_clocks", 16'(hi_cnt), 16'd4);
    check("t2_x_kept", 16'(x), 16'h0005);
    check("t2_busy", 16'(busy), 16'd0);

    // 3: two back-to-back bytes
    hi_cnt = 0;
    put(8'h05, "t3_wr0");
    put(8'hFB, "t3_wr1");
    idle(20, "t3_run");
    check("t3_hi_clocks", 16'(hi_cnt), 16'd8);
    check("t3_x_last", 16'(x), 16'h00FB);

    // 4a: 5-byte burst while idle, all accepted
    for (int i = 1; i <= 5; i++) put(8'(i), "t4a_wr");
    check("t4a_peak_level", 16'(level), 16'd4);
    idle(45, "t4a_drain");

    // 4b: burst during HOLD, fifth write dropped
    put(8'hAA, "t4b_lead");
    step("t4b_rise");
    check("t4b_in_hold", 16'(readyin), 16'd1);
    for (int i = 1; i <= 4; i++) put(8'(8'h10 + i), "t4b_wr");
    check("t4b_full", 16'({level, wr_ready}), 16'({3'd4, 1'b0}));
    put(8'h15, "t4b_wr5");
    check("t4b_still_full", 16'(level), 16'd4);
    idle(50, "t4b_drain");
    check("t4b_x_last", 16'(x), 16'h0014);

    // 5: reset in the 2nd clock of the first HOLD
    put(8'h31, "t5_wr0");
    put(8'h32, "t5_wr1");
    put(8'h33, "t5_wr2");
    check("t5_pre_hold", 16'(readyin), 16'd1);
    reset = 1'b1;
    #1;
    check("t5_async_drop", 16'(readyin), 16'd0);
    model_reset();
    idle(3, "t5_in_reset");
    reset = 1'b0;
    hi_cnt = 0;
    idle(15, "t5_after");
    check("t5_no_pulse", 16'(hi_cnt), 16'd0);
    check("t5_x_zero", 16'({x, level}), 16'd0);

    // 6: flush during the first GAP
    put(8'h41, "t6_wr0");
    put(8'h42, "t6_wr1");
    put(8'h43, "t6_wr2");
    idle(4, "t6_hold");
    check("t6_in_gap", 16'(readyin), 16'd0);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h99;
    step("t6_flush");
    flush = 1'b0;
    wr_valid = 1'b0;
    check("t6_cleared", 16'({readyin, level, busy}), 16'd0);
    hi_cnt = 0;
    idle(15, "t6_quiet");
    check("t6_no_pulse", 16'(hi_cnt), 16'd0);
    check("t6_x_kept", 16'(x), 16'h0041);
    put(8'h7E, "t6_wr7e");
    idle(12, "t6_run");
    check("t6_one_pulse", 16'(hi_cnt), 16'd4);
    check("t6_x_7e", 16'(x), 16'h007E);

    // random traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_data  = W'($urandom);
      flush    = ($urandom_range(0, 59) == 0);
      step("random");
    end
    wr_valid = 1'b0;
    flush = 1'b0;
    idle(40, "final_drain");
    check("final_idle", 16'({busy, level}), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
